// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared encodings for the multicycle RV32I core: FSM states,
//             opcodes, ALU/extender operations and datapath select values.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXCT_R  = 4'd6,
      S_EXCT_I  = 4'd7,
      S_ALU_WB  = 4'd8,
      S_BQ      = 4'd9,
      S_JAL     = 4'd10,
      S_JALR1   = 4'd11,
      S_JALR2   = 4'd12,
      S_LUI     = 4'd13,
      S_AUIPC   = 4'd14
   } state_t;

   typedef enum logic [6:0] {
      OP_L     = 7'b0000011,
      OP_I     = 7'b0010011,
      OP_AUIPC = 7'b0010111,
      OP_S     = 7'b0100011,
      OP_R     = 7'b0110011,
      OP_LUI   = 7'b0110111,
      OP_B     = 7'b1100011,
      OP_JALR  = 7'b1100111,
      OP_JAL   = 7'b1101111
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      EXT_I = 3'd0,
      EXT_S = 3'd1,
      EXT_B = 3'd2,
      EXT_U = 3'd3,
      EXT_J = 3'd4
   } ext_op_e;

   typedef enum logic [2:0] {
      BR_EQ  = 3'b000,
      BR_NE  = 3'b001,
      BR_LT  = 3'b100,
      BR_GE  = 3'b101,
      BR_LTU = 3'b110,
      BR_GEU = 3'b111
   } branch_op_e;

   typedef enum logic [2:0] {
      LD_B  = 3'b000,
      LD_H  = 3'b001,
      LD_W  = 3'b010,
      LD_BU = 3'b100,
      LD_HU = 3'b101
   } load_op_e;

   typedef enum logic [2:0] {
      ST_B = 3'b000,
      ST_H = 3'b001,
      ST_W = 3'b010
   } store_op_e;

   typedef enum logic [0:0] {
      IR_HOLD = 1'b0,
      IR_LOAD = 1'b1
   } ir_op_e;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_ALUOUT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/riscv_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_alu_decoder
//  Brief    : Maps opcode/funct3/funct7[5] of R- and I-type instructions to
//             an ALU operation; every other opcode yields ADD.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_alu_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [3:0] alu_op_o
);

   logic is_r;
   logic is_i;

   always_comb begin
      is_r     = (opcode_i == OP_R);
      is_i     = (opcode_i == OP_I);
      alu_op_o = ALU_ADD;
      if (is_r || is_i) begin
         case (funct3_i)
            // ADDI has no subtract form, so bit 30 only matters for R-type.
            3'b000:  alu_op_o = (is_r && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op_o = ALU_SLL;
            3'b010:  alu_op_o = ALU_SLT;
            3'b011:  alu_op_o = ALU_SLTU;
            3'b100:  alu_op_o = ALU_XOR;
            3'b101:  alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op_o = ALU_OR;
            default: alu_op_o = ALU_AND;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/riscv_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_controller
//  Brief    : Main control FSM of the multicycle RV32I core.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_mc_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       mem_req,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [2:0] imm_src,
   output logic [3:0] alu_ctrl,
   output logic       jalr_mask,
   output logic       illegal_instr,
   output logic       instr_done,
   output logic [3:0] state_o
);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] dec_alu_op;
   logic       ls_bad_width;

   riscv_alu_decoder u_alu_dec (
      .opcode_i   (opcode),
      .funct3_i   (funct3),
      .funct7b5_i (funct7b5),
      .alu_op_o   (dec_alu_op)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   assign state_o = state_q;

   always_comb begin
      ls_bad_width = (opcode == OP_L) ? (funct3 == 3'b011 || funct3[2:1] == 2'b11)
                                      : (funct3 > 3'b010);
   end

   always_comb begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      adr_src       = ADR_PC;
      mem_write     = 1'b0;
      mem_req       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_B;
      result_src    = RES_ALUOUT;
      imm_src       = EXT_I;
      alu_ctrl      = ALU_ADD;
      jalr_mask     = 1'b0;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
      state_d       = state_q;

      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req    = 1'b1;
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALU;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
               if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
               // ALUOut captures oldPC + imm, the branch/JAL target.
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               case (opcode)
                  OP_L:     state_d = S_MEM_ADR;
                  OP_S:     begin imm_src = EXT_S; state_d = S_MEM_ADR; end
                  OP_R:     state_d = S_EXCT_R;
                  OP_I:     state_d = S_EXCT_I;
                  OP_B:     begin imm_src = EXT_B; state_d = S_BQ; end
                  OP_JAL:   begin imm_src = EXT_J; state_d = S_JAL; end
                  OP_JALR:  state_d = S_JALR1;
                  OP_LUI:   begin imm_src = EXT_U; state_d = S_LUI; end
                  OP_AUIPC: begin imm_src = EXT_U; state_d = S_AUIPC; end
                  default:  begin illegal_instr = 1'b1; state_d = S_FETCH; end
               endcase
            end
            S_MEM_ADR: begin
               alu_src_a = SRCA_A;
               alu_src_b = SRCB_IMM;
               if (ls_bad_width) begin
                  illegal_instr = 1'b1;
                  state_d       = S_FETCH;
               end else begin
                  state_d = (opcode == OP_L) ? S_MEM_RD : S_MEM_WR;
               end
            end
            S_MEM_RD: begin
               adr_src = ADR_ALUOUT;
               mem_req = 1'b1;
               if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
               result_src = RES_DATA;
               reg_write  = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEM_WR: begin
               adr_src    = ADR_ALUOUT;
               mem_req    = 1'b1;
               mem_write  = 1'b1;
               instr_done = mem_ready;
               if (mem_ready) state_d = S_FETCH;
            end
            S_EXCT_R: begin
               alu_src_a = SRCA_A;
               alu_ctrl  = dec_alu_op;
               state_d   = S_ALU_WB;
            end
            S_EXCT_I: begin
               alu_src_a = SRCA_A;
               alu_src_b = SRCB_IMM;
               alu_ctrl  = dec_alu_op;
               state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_BQ: begin
               alu_src_a  = SRCA_A;
               alu_ctrl   = ALU_SUB;
               instr_done = 1'b1;
               state_d    = S_FETCH;
               case (funct3)
                  BR_EQ:   pc_write = zero;
                  BR_NE:   pc_write = !zero;
                  BR_LT:   pc_write = lt;
                  BR_GE:   pc_write = !lt;
                  BR_LTU:  pc_write = ltu;
                  BR_GEU:  pc_write = !ltu;
                  default: illegal_instr = 1'b1;
               endcase
            end
            S_JAL: begin
               // PC loads the target held in ALUOut while the ALU forms the link.
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_FOUR;
               pc_write  = 1'b1;
               state_d   = S_ALU_WB;
            end
            S_JALR1: begin
               alu_src_a = SRCA_A;
               alu_src_b = SRCB_IMM;
               state_d   = S_JALR2;
            end
            S_JALR2: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_FOUR;
               pc_write  = 1'b1;
               jalr_mask = 1'b1;
               state_d   = S_ALU_WB;
            end
            S_LUI: begin
               alu_src_a = SRCA_ZERO;
               alu_src_b = SRCB_IMM;
               imm_src   = EXT_U;
               state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               imm_src   = EXT_U;
               state_d   = S_ALU_WB;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mc_controller
//  Brief    : Scoreboard bench for the multicycle control FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_controller;
   import riscv_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero, lt, ltu, mem_ready;
   logic       pc_write, ir_write, adr_src, mem_write, mem_req, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [2:0] imm_src;
   logic [3:0] alu_ctrl;
   logic       jalr_mask, illegal_instr, instr_done;
   logic [3:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [25:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   riscv_mc_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
      .mem_write(mem_write), .mem_req(mem_req), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .imm_src(imm_src), .alu_ctrl(alu_ctrl), .jalr_mask(jalr_mask),
      .illegal_instr(illegal_instr), .instr_done(instr_done), .state_o(state_o)
   );

   // en = {pc_write, ir_write, adr_src, mem_write, mem_req, reg_write}
   // misc = {jalr_mask, illegal_instr, instr_done}
   function automatic logic [25:0] mk(input logic [3:0] st, input logic [5:0] en,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] rs, input logic [2:0] imm,
                                      input logic [3:0] alu, input logic [2:0] misc);
      return {st, en, sa, sb, rs, imm, alu, misc};
   endfunction

   task automatic check(input string tag, input logic [25:0] got, input logic [25:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [25:0] e;
         logic [25:0] a;
         string       t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {state_o, pc_write, ir_write, adr_src, mem_write, mem_req, reg_write,
              alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl,
              jalr_mask, illegal_instr, instr_done};
         check({t, ".state"}, {22'd0, a[25:22]}, {22'd0, e[25:22]});
         check({t, ".ctrl"},  {4'd0, a[21:0]},   {4'd0, e[21:0]});
      end
   end

   task automatic step(input string tag, input logic [25:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic b5);
      opcode = op; funct3 = f3; funct7b5 = b5;
   endtask

   task automatic fetch(input string tag);
      mem_ready = 1'b1;
      step({tag, ".fetch"}, mk(S_FETCH, 6'b110010, SRCA_PC, SRCB_FOUR, RES_ALU, EXT_I, ALU_ADD, 3'b000));
   endtask

   task automatic decode(input string tag, input logic [2:0] imm, input logic ill);
      step({tag, ".decode"}, mk(S_DECODE, 6'b0, SRCA_OLDPC, SRCB_IMM, RES_ALUOUT, imm, ALU_ADD, {1'b0, ill, 1'b0}));
   endtask

   task automatic alu_wb(input string tag);
      step({tag, ".wb"}, mk(S_ALU_WB, 6'b000001, SRCA_PC, SRCB_B, RES_ALUOUT, EXT_I, ALU_ADD, 3'b001));
   endtask

   task automatic arith(input string tag, input logic is_r, input logic [2:0] f3,
                        input logic b5, input logic [3:0] want_alu);
      set_ir(is_r ? 7'h33 : 7'h13, f3, b5);
      fetch(tag);
      decode(tag, EXT_I, 1'b0);
      if (is_r) step({tag, ".exct"}, mk(S_EXCT_R, 6'b0, SRCA_A, SRCB_B,   RES_ALUOUT, EXT_I, want_alu, 3'b000));
      else      step({tag, ".exct"}, mk(S_EXCT_I, 6'b0, SRCA_A, SRCB_IMM, RES_ALUOUT, EXT_I, want_alu, 3'b000));
      alu_wb(tag);
   endtask

   task automatic branch(input string tag, input logic [2:0] f3, input logic z,
                         input logic l, input logic lu, input logic taken, input logic ill);
      set_ir(7'h63, f3, 1'b0);
      fetch(tag);
      decode(tag, EXT_B, 1'b0);
      zero = z; lt = l; ltu = lu;
      step({tag, ".bq"}, mk(S_BQ, {taken, 5'b0}, SRCA_A, SRCB_B, RES_ALUOUT, EXT_I, ALU_SUB, {1'b0, ill, 1'b1}));
      zero = 1'b0; lt = 1'b0; ltu = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      set_ir(7'h00, 3'b000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      step("reset", mk(S_FETCH, 6'b0, 2'b00, 2'b00, 2'b00, EXT_I, ALU_ADD, 3'b000));
      rst = 1'b0;

      // add x3,x1,x2 (0x002081B3) and other ALU decodes
      arith("add",  1'b1, 3'b000, 1'b0, ALU_ADD);
      arith("sub",  1'b1, 3'b000, 1'b1, ALU_SUB);
      arith("srl",  1'b1, 3'b101, 1'b0, ALU_SRL);
      arith("sltu", 1'b1, 3'b011, 1'b0, ALU_SLTU);
      arith("addi", 1'b0, 3'b000, 1'b1, ALU_ADD);
      arith("srai", 1'b0, 3'b101, 1'b1, ALU_SRA);
      arith("andi", 1'b0, 3'b111, 1'b0, ALU_AND);

      // lw x5,8(x1) with three wait cycles
      set_ir(7'h03, 3'b010, 1'b0);
      fetch("lw");
      decode("lw", EXT_I, 1'b0);
      step("lw.adr", mk(S_MEM_ADR, 6'b0, SRCA_A, SRCB_IMM, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         step("lw.rd", mk(S_MEM_RD, 6'b001010, SRCA_PC, SRCB_B, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      end
      mem_ready = 1'b0;
      step("lw.wb", mk(S_MEM_WB, 6'b000001, SRCA_PC, SRCB_B, RES_DATA, EXT_I, ALU_ADD, 3'b001));

      branch("bne",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      branch("beq",  3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      branch("bltu", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      branch("bge",  3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      branch("b010", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

      // jalr x1,4(x2)
      set_ir(7'h67, 3'b000, 1'b0);
      fetch("jalr");
      decode("jalr", EXT_I, 1'b0);
      step("jalr.1", mk(S_JALR1, 6'b0, SRCA_A, SRCB_IMM, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      step("jalr.2", mk(S_JALR2, 6'b100000, SRCA_OLDPC, SRCB_FOUR, RES_ALUOUT, EXT_I, ALU_ADD, 3'b100));
      alu_wb("jalr");

      set_ir(7'h6F, 3'b000, 1'b0);
      fetch("jal");
      decode("jal", EXT_J, 1'b0);
      step("jal.j", mk(S_JAL, 6'b100000, SRCA_OLDPC, SRCB_FOUR, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      alu_wb("jal");

      set_ir(7'h37, 3'b000, 1'b0);
      fetch("lui");
      decode("lui", EXT_U, 1'b0);
      step("lui.x", mk(S_LUI, 6'b0, SRCA_ZERO, SRCB_IMM, RES_ALUOUT, EXT_U, ALU_ADD, 3'b000));
      alu_wb("lui");

      set_ir(7'h17, 3'b000, 1'b0);
      fetch("auipc");
      decode("auipc", EXT_U, 1'b0);
      step("auipc.x", mk(S_AUIPC, 6'b0, SRCA_OLDPC, SRCB_IMM, RES_ALUOUT, EXT_U, ALU_ADD, 3'b000));
      alu_wb("auipc");

      // illegal opcode 0x00
      set_ir(7'h00, 3'b000, 1'b0);
      fetch("ill");
      decode("ill", EXT_I, 1'b1);
      fetch("ill.next");

      // load of width 011 is illegal
      set_ir(7'h03, 3'b011, 1'b0);
      decode("ldbad", EXT_I, 1'b0);
      step("ldbad.adr", mk(S_MEM_ADR, 6'b0, SRCA_A, SRCB_IMM, RES_ALUOUT, EXT_I, ALU_ADD, 3'b010));
      fetch("ldbad.next");

      // store stalled in MEM_WR, then reset
      set_ir(7'h23, 3'b010, 1'b0);
      decode("sw", EXT_S, 1'b0);
      step("sw.adr", mk(S_MEM_ADR, 6'b0, SRCA_A, SRCB_IMM, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      mem_ready = 1'b0;
      step("sw.wr0", mk(S_MEM_WR, 6'b001110, SRCA_PC, SRCB_B, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      step("sw.wr1", mk(S_MEM_WR, 6'b001110, SRCA_PC, SRCB_B, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      rst = 1'b1;
      step("sw.rst0", mk(S_MEM_WR, 6'b0, SRCA_PC, SRCB_B, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      step("sw.rst1", mk(S_FETCH,  6'b0, SRCA_PC, SRCB_B, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      rst = 1'b0;
      step("stall.fetch", mk(S_FETCH, 6'b000010, SRCA_PC, SRCB_FOUR, RES_ALU, EXT_I, ALU_ADD, 3'b000));

      // complete store, then a bad store width
      fetch("sw2");
      decode("sw2", EXT_S, 1'b0);
      step("sw2.adr", mk(S_MEM_ADR, 6'b0, SRCA_A, SRCB_IMM, RES_ALUOUT, EXT_I, ALU_ADD, 3'b000));
      mem_ready = 1'b1;
      step("sw2.wr", mk(S_MEM_WR, 6'b001110, SRCA_PC, SRCB_B, RES_ALUOUT, EXT_I, ALU_ADD, 3'b001));
      set_ir(7'h23, 3'b011, 1'b0);
      fetch("swbad");
      decode("swbad", EXT_S, 1'b0);
      step("swbad.adr", mk(S_MEM_ADR, 6'b0, SRCA_A, SRCB_IMM, RES_ALUOUT, EXT_I, ALU_ADD, 3'b010));
      fetch("swbad.next");

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
Main control FSM of the multicycle RV32I core. It sequences the shared datapath (PC, IR, oldPC, A/B, ALUOut, Data registers, one ALU, one unified memory port) through the `state_t` states. It decodes the opcode, funct3 and funct7[5] held in IR into mux selects, write enables, `ext_op_e` and `alu_op_e`. It evaluates branch conditions from ALU flags and stalls on the memory ready handshake.

Parameters:
None. All widths and encodings come from `riscv_pkg`.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0], compared against `opcode_e`
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR and oldPC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  store strobe
- mem_req  out  1  memory access valid
- reg_write  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = A, 11 = zero
- alu_src_b  out  2  ALU B select: 00 = B, 01 = imm, 10 = const 4
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU direct
- imm_src  out  3  `ext_op_e`
- alu_ctrl  out  4  `alu_op_e`
- jalr_mask  out  1  clear bit 0 of the PC load value
- illegal_instr  out  1  one-cycle pulse
- instr_done  out  1  one-cycle pulse when an instruction retires
- state_o  out  4  current state, for debug

Behaviour:
- **Reset.** When rst is high at a clock edge, state becomes S_FETCH. While rst is high, all enables and strobes (pc_write, ir_write, mem_write, mem_req, reg_write, illegal_instr, instr_done) are 0. All selects are 0, alu_ctrl = ALU_ADD, imm_src = EXT_I. Reset during any state, including a stalled S_MEM_WR, aborts the instruction with no further writes.
- **Output timing.** Outputs are combinational from the state register and the IR fields. Default for every output is 0 / ALU_ADD / EXT_I unless a state below says otherwise.
- **S_FETCH.** adr_src=0, mem_req=1, A=PC, B=4, ADD, result_src=10. ir_write and pc_write equal mem_ready. The FSM holds in this state while mem_ready=0 and moves to S_DECODE when mem_ready=1.
- **S_DECODE.** A=oldPC, B=imm, ADD. ALUOut becomes the branch/JAL target. imm_src per opcode: L/I/JALR = I, S = S, B = B, JAL = J, LUI/AUIPC = U. Next state by opcode:
  - L, S → S_MEM_ADR
  - R → S_EXCT_R
  - I → S_EXCT_I
  - B → S_BQ
  - JAL → S_JAL
  - JALR → S_JALR1
  - LUI → S_LUI
  - AUIPC → S_AUIPC
  - any other value, including 0 → S_FETCH with illegal_instr=1
- **S_MEM_ADR.** A=A, B=imm, ADD. Next is S_MEM_RD for a load, S_MEM_WR for a store.
- **S_MEM_RD.** adr_src=1, mem_req=1. Holds until mem_ready, then → S_MEM_WB.
- **S_MEM_WB.** result_src=01, reg_write=1, instr_done=1 → S_FETCH.
- **S_MEM_WR.** adr_src=1, mem_req=1, mem_write=1, held until mem_ready. Then instr_done=1 → S_FETCH.
- **S_EXCT_R.** A=A, B=B → S_ALU_WB.
- **S_EXCT_I.** A=A, B=imm → S_ALU_WB.
- **S_ALU_WB.** result_src=00, reg_write=1, instr_done=1 → S_FETCH.
- **ALU decode for funct3 (R and I types).**
  - 000: ADD, or SUB only if R-type and funct7b5=1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7b5=1, else SRL (R and I)
  - 110: OR
  - 111: AND
- **S_BQ.** A=A, B=B, SUB, result_src=00, instr_done=1 → S_FETCH. pc_write = taken, where taken is:
  - BEQ: zero
  - BNE: !zero
  - BLT: lt
  - BGE: !lt
  - BLTU: ltu
  - BGEU: !ltu
  - funct3 010 or 011: not taken, and illegal_instr=1
- **S_JAL.** A=oldPC, B=4, ADD, result_src=00, pc_write=1 → S_ALU_WB. PC takes the target; ALUOut takes the link address.
- **S_JALR1.** A=A, B=imm, ADD → S_JALR2.
- **S_JALR2.** A=oldPC, B=4, ADD, result_src=00, pc_write=1, jalr_mask=1 → S_ALU_WB.
- **S_LUI.** A=zero, B=imm, imm_src=EXT_U → S_ALU_WB.
- **S_AUIPC.** A=oldPC, B=imm, imm_src=EXT_U → S_ALU_WB.
- **Illegal load/store widths.** Load funct3 of 011, 110 or 111, or store funct3 above 010, pulses illegal_instr in S_MEM_ADR and returns to S_FETCH without a memory access.
- **Cycle counts with mem_ready=1 throughout.** R/I/LUI/AUIPC = 4, load = 5, store = 4, branch = 3, JAL = 4, JALR = 5.

Decomposition:
- `state_t`, `opcode_e`, `alu_op_e`, `ext_op_e`, `branch_op_e`, `load_op_e`, `store_op_e` and `ir_op_e` are already in `riscv_pkg`.
- Add the select encodings to `riscv_pkg` as localparams: `SRCA_*`, `SRCB_*`, `RES_*`, `ADR_*`.
- One sub-module, `riscv_alu_decoder`, maps (opcode, funct3, funct7b5) to `alu_op_e`. It is combinational. The FSM overrides its output with ADD or SUB where the states above specify.

Test Plan:
- **R-type ADD.** Fetch `add x3,x1,x2` (0x002081B3) with mem_ready=1 → states FETCH, DECODE, EXCT_R, ALU_WB. alu_ctrl=ALU_ADD in EXCT_R. reg_write=1 in cycle 4 only, instr_done=1 in the same cycle.
- **Load with memory wait.** `lw x5,8(x1)` with mem_ready low for 3 cycles in MEM_RD → FSM holds MEM_RD for 4 cycles with mem_req=1 and reg_write=0. Then MEM_WB with result_src=01. Total 8 cycles.
- **Branch taken and not taken.** BNE with zero=1 → pc_write=0 in BQ. BLTU with ltu=1 → pc_write=1. funct3=010 → illegal_instr pulse and not taken.
- **JALR.** `jalr x1,4(x2)` → DECODE, JALR1, JALR2, ALU_WB. jalr_mask=1 and pc_write=1 only in JALR2. reg_write in ALU_WB.
- **Illegal opcode.** opcode 0x00 → illegal_instr=1 for exactly one cycle in DECODE. Next state FETCH, no reg_write or mem_write.
- **Reset mid-store.** Assert rst while in MEM_WR with mem_ready=0 → next cycle state_o=S_FETCH, and mem_write=0 while rst is high.
